// File: rtl/flags_scanner_if.sv
// Stream/control bundle between the flags register read port, flags_scanner and its consumer.
// Clear-on-read signals exist only when FLAGS_SCAN_CLEAR_EN is defined.
interface flags_scanner_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
);
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH;
    localparam int NUM_FLAGS = MAX_DIM * MAX_DIM;
    localparam int POS_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int CNT_W     = $clog2(NUM_FLAGS + 1);

    logic                 start_i;
    logic [NUM_FLAGS-1:0] flags_i;
    logic                 idx_ready_i;
    logic                 idx_valid_o;
    logic [POS_W-1:0]     row_o;
    logic [POS_W-1:0]     col_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 any_flag_o;
    logic [CNT_W-1:0]     count_o;
`ifdef FLAGS_SCAN_CLEAR_EN
    logic                 clr_o;
    logic [NUM_FLAGS-1:0] clr_mask_o;
`endif

`ifdef FLAGS_SCAN_CLEAR_EN
    modport slave (
        input  start_i, flags_i, idx_ready_i,
        output idx_valid_o, row_o, col_o, busy_o, done_o, any_flag_o, count_o,
        output clr_o, clr_mask_o
    );
    modport master (
        output start_i, flags_i, idx_ready_i,
        input  idx_valid_o, row_o, col_o, busy_o, done_o, any_flag_o, count_o,
        input  clr_o, clr_mask_o
    );
`else
    modport slave (
        input  start_i, flags_i, idx_ready_i,
        output idx_valid_o, row_o, col_o, busy_o, done_o, any_flag_o, count_o
    );
    modport master (
        output start_i, flags_i, idx_ready_i,
        input  idx_valid_o, row_o, col_o, busy_o, done_o, any_flag_o, count_o
    );
`endif
endinterface

// File: rtl/flags_scanner.sv
// Snapshots the over/underflow flag vector on start and streams the (row,col) of every set bit.
// Define FLAGS_SCAN_CLEAR_EN to add a one-hot clear-on-read pulse after each accepted index.
module flags_scanner #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
) (
    input logic              clk_i,
    input logic              rst_ni,
    flags_scanner_if.slave   bus
);
    // state | meaning
    // IDLE  | waiting for start_i
    // SCAN  | testing snapshot bit at ptr, one bit per cycle
    // EMIT  | presenting (row,col) until the consumer accepts it
    // DONE  | one-cycle completion pulse with final count
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH;
    localparam int NUM_FLAGS = MAX_DIM * MAX_DIM;
    localparam int POS_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int CNT_W     = $clog2(NUM_FLAGS + 1);
    localparam int PTR_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [NUM_FLAGS-1:0] snapshot_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [POS_W-1:0]     row_q;
    logic [POS_W-1:0]     col_q;
    logic                 any_flag_q;
    logic                 last_bit;
    logic                 handshake;

    assign last_bit  = (ptr_q == PTR_W'(NUM_FLAGS - 1));
    assign handshake = (state_q == EMIT) && bus.idx_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            any_flag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        snapshot_q <= bus.flags_i;
                        ptr_q      <= '0;
                        count_q    <= '0;
                        any_flag_q <= |bus.flags_i;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (snapshot_q[ptr_q]) begin
                        row_q   <= POS_W'(ptr_q / PTR_W'(MAX_DIM));
                        col_q   <= POS_W'(ptr_q % PTR_W'(MAX_DIM));
                        state_q <= EMIT;
                    end else if (last_bit) begin
                        state_q <= DONE;
                    end else begin
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        count_q <= count_q + CNT_W'(1);
                        if (last_bit) begin
                            state_q <= DONE;
                        end else begin
                            ptr_q   <= ptr_q + PTR_W'(1);
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FLAGS_SCAN_CLEAR_EN
    logic                 clr_q;
    logic [NUM_FLAGS-1:0] clr_mask_q;

    // Mask names the bit just accepted so the register clears exactly what was reported.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_q      <= 1'b0;
            clr_mask_q <= '0;
        end else begin
            clr_q      <= handshake;
            clr_mask_q <= handshake ? (NUM_FLAGS'(1) << ptr_q) : '0;
        end
    end

    assign bus.clr_o      = clr_q;
    assign bus.clr_mask_o = clr_mask_q;
`endif

    assign bus.idx_valid_o = (state_q == EMIT);
    assign bus.busy_o      = (state_q == SCAN) || (state_q == EMIT);
    assign bus.done_o      = (state_q == DONE);
    assign bus.row_o       = row_q;
    assign bus.col_o       = col_q;
    assign bus.any_flag_o  = any_flag_q;
    assign bus.count_o     = count_q;
endmodule
